// File: rtl/bram_port_req_adapter_pkg.sv
// Shared types and helpers for the BRAM port request adapter.
// Optional feature macro: BRAM_PORT_REQ_ADAPTER_ALIGN_CHECK_EN (see top module).
package bram_port_req_adapter_pkg;

   // Per-response side information that travels alongside the data word.
   typedef struct packed {
      logic we;   // response belongs to a write
      logic err;  // request was misaligned and never reached the BRAM
   } rsp_meta_t;

   localparam int RSP_META_W = $bits(rsp_meta_t);

   // Number of byte-offset bits inside one word of the given width.
   function automatic int byte_offset_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Synchronous show-ahead FIFO holding BRAM responses.
// The head entry is visible on o_head_data whenever o_empty is low; a pop
// advances to the next entry at the clock edge. Pushes into a full FIFO and
// pops from an empty FIFO are ignored so the occupancy can never wrap.
module bram_rsp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Pointers advance modulo DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign o_empty     = (o_count == '0);
   assign o_full      = (o_count == CNT_W'(DEPTH));
   assign push_ok     = i_push && !o_full;
   assign pop_ok      = i_pop && !o_empty;
   assign o_head_data = mem[rd_ptr];

   // Storage array: data only, written on push.
   // NOTE: the data array has no reset; occupancy is tracked by the reset
   // pointers/count, so stale contents are never presented as valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop_ok) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push_ok, pop_ok})
            2'b10:   o_count <= o_count + 1'b1;
            2'b01:   o_count <= o_count - 1'b1;
            default: o_count <= o_count;
         endcase
      end
   end

endmodule

// File: rtl/bram_port_req_adapter.sv
// Valid/ready front end for one port of a true dual-port BRAM.
// Requests are turned into single-cycle BRAM strobes; the BRAM's one-cycle
// read latency is absorbed by an inflight register plus a response FIFO with
// a bypass path, so a response can appear the cycle after acceptance.
// Request acceptance is gated on total outstanding work (FIFO + inflight),
// so BRAM read data always has a slot and is never dropped.
// Optional feature macro: BRAM_PORT_REQ_ADAPTER_ALIGN_CHECK_EN
//   defined   : misaligned requests skip the BRAM and respond with err=1, data 0
//   undefined : low address bits are passed through; o_rsp_err is always 0
module bram_port_req_adapter
   import bram_port_req_adapter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RSP_DEPTH  = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [DATA_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   input  logic                  i_req_we,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic                  o_rsp_we,
   output logic                  o_rsp_err,
   output logic                  o_bram_enable,
   output logic [DATA_WIDTH-1:0] o_bram_byte_address,
   output logic [DATA_WIDTH-1:0] o_bram_write_data,
   output logic                  o_bram_write_enable,
   input  logic [DATA_WIDTH-1:0] i_bram_read_data
);

   localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
   localparam int ENTRY_W = DATA_WIDTH + RSP_META_W;

   logic                  accept;
   logic                  misaligned;
   logic                  inflight_valid;
   rsp_meta_t             inflight_meta;
   logic [DATA_WIDTH-1:0] inflight_data;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [ENTRY_W-1:0]    fifo_head;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_empty;
   logic                  fifo_full;
   rsp_meta_t             head_meta;

`ifdef BRAM_PORT_REQ_ADAPTER_ALIGN_CHECK_EN
   localparam int OFF_W = byte_offset_bits(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'((1 << OFF_W) - 1);
   assign misaligned = |(i_req_addr & ALIGN_MASK);
`else
   assign misaligned = 1'b0;
`endif

   // Ready depends only on registered occupancy, never on i_rsp_ready.
   assign o_req_ready = (int'(fifo_count) + int'(inflight_valid)) < RSP_DEPTH;
   assign accept      = i_req_valid && o_req_ready;

   // BRAM port drive is a direct combinational pass-through of the request.
   assign o_bram_enable       = accept && !misaligned;
   assign o_bram_byte_address = i_req_addr;
   assign o_bram_write_data   = i_req_wdata;
   assign o_bram_write_enable = o_bram_enable && i_req_we;

   // Track the request whose BRAM data arrives on the next cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inflight_valid <= 1'b0;
         inflight_meta  <= '0;
      end else begin
         inflight_valid <= accept;
         if (accept) begin
            inflight_meta <= '{we: i_req_we, err: misaligned};
         end
      end
   end

   // Misaligned entries never touched the BRAM, so their data is forced to 0.
   assign inflight_data = inflight_meta.err ? '0 : i_bram_read_data;

   // The inflight word bypasses the FIFO when it is empty and the consumer is
   // ready; otherwise it is stored so backpressure cannot lose it.
   assign fifo_push = inflight_valid && !(fifo_empty && i_rsp_ready) && !fifo_full;
   assign fifo_pop  = !fifo_empty && i_rsp_ready;

   bram_rsp_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (fifo_push),
      .i_push_data ({inflight_data, inflight_meta}),
      .i_pop       (fifo_pop),
      .o_head_data (fifo_head),
      .o_count     (fifo_count),
      .o_empty     (fifo_empty),
      .o_full      (fifo_full)
   );

   // Present the FIFO head, or the inflight word directly when the FIFO is empty.
   // NOTE: every output gets a default at the top of the block so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      o_rsp_valid = 1'b0;
      o_rsp_data  = '0;
      head_meta   = '0;
      if (!fifo_empty) begin
         o_rsp_valid = 1'b1;
         o_rsp_data  = fifo_head[ENTRY_W-1:RSP_META_W];
         head_meta   = fifo_head[RSP_META_W-1:0];
      end else if (inflight_valid) begin
         o_rsp_valid = 1'b1;
         o_rsp_data  = inflight_data;
         head_meta   = inflight_meta;
      end
      o_rsp_we  = head_meta.we;
      o_rsp_err = head_meta.err;
   end

endmodule

// File: tb/tb_bram_port_req_adapter.sv
// Self-checking bench for bram_port_req_adapter with a write-first BRAM model.
// Honours BRAM_PORT_REQ_ADAPTER_ALIGN_CHECK_EN for the expected err behaviour.
module tb_bram_port_req_adapter;

   localparam int DW        = 32;
   localparam int RSP_DEPTH = 3;
`ifdef BRAM_PORT_REQ_ADAPTER_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_req_valid = 1'b0;
   logic          o_req_ready;
   logic [DW-1:0] i_req_addr = '0;
   logic [DW-1:0] i_req_wdata = '0;
   logic          i_req_we = 1'b0;
   logic          o_rsp_valid;
   logic          i_rsp_ready = 1'b1;
   logic [DW-1:0] o_rsp_data;
   logic          o_rsp_we;
   logic          o_rsp_err;
   logic          o_bram_enable;
   logic [DW-1:0] o_bram_byte_address;
   logic [DW-1:0] o_bram_write_data;
   logic          o_bram_write_enable;
   logic [DW-1:0] i_bram_read_data;

   bram_port_req_adapter #(
      .DATA_WIDTH (DW),
      .RSP_DEPTH  (RSP_DEPTH)
   ) dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_req_valid         (i_req_valid),
      .o_req_ready         (o_req_ready),
      .i_req_addr          (i_req_addr),
      .i_req_wdata         (i_req_wdata),
      .i_req_we            (i_req_we),
      .o_rsp_valid         (o_rsp_valid),
      .i_rsp_ready         (i_rsp_ready),
      .o_rsp_data          (o_rsp_data),
      .o_rsp_we            (o_rsp_we),
      .o_rsp_err           (o_rsp_err),
      .o_bram_enable       (o_bram_enable),
      .o_bram_byte_address (o_bram_byte_address),
      .o_bram_write_data   (o_bram_write_data),
      .o_bram_write_enable (o_bram_write_enable),
      .i_bram_read_data    (i_bram_read_data)
   );

   always #5 i_clk = ~i_clk;

   // Edge counter used for latency checks.
   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Write-first BRAM port model with one-cycle read latency.
   logic [DW-1:0] bram_mem [256];
   always @(posedge i_clk) begin
      if (o_bram_enable) begin
         if (o_bram_write_enable) begin
            bram_mem[o_bram_byte_address[9:2]] <= o_bram_write_data;
            i_bram_read_data <= o_bram_write_data;
         end else begin
            i_bram_read_data <= bram_mem[o_bram_byte_address[9:2]];
         end
      end
   end

   // Reference model: word-addressed memory plus in-order expected responses.
   typedef struct {
      logic [DW-1:0] data;
      logic          we;
      logic          err;
      int            acc_edge;
      bit            strict;
   } exp_t;

   logic [DW-1:0] model_mem [256];
   exp_t          sb[$];
   exp_t          mon_e;

   int total = 0;
   int bad = 0;
   int pops = 0;
   int stall_cycles = 0;
   int rsp_mode = 1;  // 0: hold low, 1: hold high, 2: random

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Called on the negedge before an accepting edge: check strobes, update model.
   task automatic record(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                         input bit strict);
      exp_t e;
      logic err;
      err = ALIGN_EN && (addr[1:0] != 2'b00);
      check("bram_enable", o_bram_enable, {31'b0, !err});
      if (!err) begin
         check("bram_we", o_bram_write_enable, {31'b0, we});
         check("bram_addr", o_bram_byte_address, addr);
         if (we) check("bram_wdata", o_bram_write_data, wd);
      end
      if (err) begin
         e.data = '0;
      end else if (we) begin
         e.data = wd;
         model_mem[addr[9:2]] = wd;
      end else begin
         e.data = model_mem[addr[9:2]];
      end
      e.we       = we;
      e.err      = err;
      e.acc_edge = cyc + 1;
      e.strict   = strict;
      sb.push_back(e);
   endtask

   // Drive one request and hold it until accepted (bounded wait).
   task automatic issue(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                        input bit strict);
      int waits = 0;
      bit done = 0;
      i_req_valid = 1'b1;
      i_req_we    = we;
      i_req_addr  = addr;
      i_req_wdata = wd;
      while (!done) begin
         @(negedge i_clk);
         if (o_req_ready) begin
            record(we, addr, wd, strict);
            done = 1;
         end else begin
            check("bram_idle_when_stalled", o_bram_enable, 0);
            stall_cycles++;
            waits++;
            if (waits > 200) begin
               check("req_accept_timeout", 0, 1);
               done = 1;
            end
         end
         step();
      end
   endtask

   task automatic drain();
      int n = 0;
      i_req_valid = 1'b0;
      while (sb.size() != 0 && n < 300) begin
         step();
         n++;
      end
      check("drain_outstanding", sb.size(), 0);
      check("drain_rsp_valid", o_rsp_valid, 0);
   endtask

   // Response-ready driver.
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         case (rsp_mode)
            0:       i_rsp_ready = 1'b0;
            1:       i_rsp_ready = 1'b1;
            default: i_rsp_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Monitor: compare every delivered response against the scoreboard head.
   always @(negedge i_clk) begin
      if (i_rst_n && o_rsp_valid && i_rsp_ready) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            pops++;
            check("rsp_data", o_rsp_data, mon_e.data);
            check("rsp_we", o_rsp_we, mon_e.we);
            check("rsp_err", o_rsp_err, mon_e.err);
            if (mon_e.strict) check("rsp_latency", cyc, mon_e.acc_edge);
         end
      end
   end

   initial begin
      int accepted;
      int pops0;
      int k;
      for (int i = 0; i < 256; i++) begin
         bram_mem[i]  = '0;
         model_mem[i] = '0;
      end

      // Reset state.
      #2;
      check("reset_rsp_valid", o_rsp_valid, 0);
      check("reset_req_ready", o_req_ready, 1);
      check("reset_bram_enable", o_bram_enable, 0);
      repeat (3) step();
      i_rst_n = 1'b1;
      step();
      check("post_reset_req_ready", o_req_ready, 1);

      // Read after write, back to back.
      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 1'b1);
      drain();

      // Streaming 16 reads with the consumer always ready.
      for (int i = 0; i < 8; i++) issue(1'b1, 32'h40 + 32'(i * 4), $urandom, 1'b0);
      drain();
      stall_cycles = 0;
      pops0 = pops;
      for (int i = 0; i < 16; i++) issue(1'b0, 32'h40 + 32'((i % 8) * 4), 32'h0, 1'b1);
      drain();
      check("stream_no_stall", stall_cycles, 0);
      check("stream_rsp_count", pops - pops0, 16);

      // Backpressure: no consumer, continuous reads.
      rsp_mode = 0;
      step();
      step();
      accepted = 0;
      k = 0;
      pops0 = pops;
      i_req_valid = 1'b1;
      i_req_we    = 1'b0;
      for (int c = 0; c < 8; c++) begin
         i_req_addr = 32'h40 + 32'(k * 4);
         @(negedge i_clk);
         if (o_req_ready) begin
            record(1'b0, i_req_addr, 32'h0, 1'b0);
            accepted++;
            k++;
         end
         step();
      end
      check("bp_accept_count", accepted, RSP_DEPTH);
      check("bp_req_ready_low", o_req_ready, 0);
      check("bp_rsp_valid_held", o_rsp_valid, 1);
      i_req_valid = 1'b0;
      rsp_mode = 1;
      drain();
      check("bp_rsp_count", pops - pops0, RSP_DEPTH);

      // Misaligned read: error response when the check is built in,
      // otherwise the containing word.
      issue(1'b0, 32'h12, 32'h0, 1'b1);
      drain();

      // Randomized traffic with random consumer backpressure.
      rsp_mode = 2;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            i_req_valid = 1'b0;
            step();
         end else begin
            issue(1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 15) * 4) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0),
                  $urandom, 1'b0);
         end
      end
      i_req_valid = 1'b0;
      rsp_mode = 1;
      drain();

      // Reset with responses queued.
      rsp_mode = 0;
      step();
      step();
      issue(1'b0, 32'h10, 32'h0, 1'b0);
      issue(1'b0, 32'h14, 32'h0, 1'b0);
      i_req_valid = 1'b0;
      step();
      step();
      check("rst_mid_rsp_queued", o_rsp_valid, 1);
      i_rst_n = 1'b0;
      #1;
      check("rst_mid_rsp_valid", o_rsp_valid, 0);
      sb.delete();
      step();
      step();
      i_rst_n = 1'b1;
      rsp_mode = 1;
      step();
      step();
      check("rst_mid_req_ready", o_req_ready, 1);
      check("rst_mid_no_rsp", o_rsp_valid, 0);
      issue(1'b0, 32'h10, 32'h0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
